fifoc2cs: RTL and testbench
===========================

// Module: fifoc2cs
// PURPOSE
//  Command-frame parser on the sys_clk side of the command FIFO (fifoc). After mac2fifoc has written a received UDP payload into fifoc,
//  this block pops data_len bytes, checks header and checksum, and drives the nine command registers (cmd_kdev..cmd_reg7)
//  consumed by the ADC control path. Registers update atomically, and only on a valid frame; any bad frame raises err.
// PARAMETERS
//  HEAD0      8'h55  first header byte
//  HEAD1      8'hAA  second header byte
//  FRAME_LEN  12     valid frame length in bytes: 2 header + 9 command + 1 checksum
// PORTS
//  clk         in   1   system clock (sys_clk); single clock domain
//  rst         in   1   synchronous, active-high reset
//  fs          in   1   start: level, held high by controller until fd seen
//  fd          out  1   done: high in DONE state until fs drops
//  data_len    in   12  byte count in fifoc for this frame (eth_rx_len); sampled in IDLE when fs=1
//  fifoc_rxen  out  1   fifoc read enable; dout valid 1 clk after rxen
//  fifoc_rxd   in   8   fifoc read data
//  cmd_kdev,cmd_smpr,cmd_filt,cmd_mix0,cmd_mix1,cmd_reg4..cmd_reg7  out 8 each  command regs, frame bytes 2..10 in order
//  err         out  1   frame error of last transaction (err_fifoc2cs)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, shadow regs and checksum cleared. A reset mid-frame aborts it: no commit, cmd regs forced to 0.
//  FSM: IDLE -> READ -> LAST -> CHECK -> DONE -> IDLE.
//  IDLE: when fs=1, latch len=data_len, clear rd_cnt, cap_idx, sum, err. Go to READ if len!=0; if len==0, go to CHECK with len_err=1.
//  READ: fifoc_rxen=1 for exactly len cycles (rd_cnt 0..len-1); on rd_cnt==len-1 go to LAST.
//  Capture pipeline: rxen delayed 1 clk = cap_vld. On each cap_vld, byte fifoc_rxd has index cap_idx, and cap_idx increments.
//  LAST: rxen=0; final byte captured this cycle; go to CHECK.
//  Capture rules (cap_idx < FRAME_LEN only):
//   - idx0 must equal HEAD0 and idx1 must equal HEAD1, else hdr_err.
//   - idx2..10 are stored to shadow[0..8], and sum = sum + byte (8-bit wrap).
//   - idx11 is stored as chk.
//   - Bytes with idx >= FRAME_LEN are popped and discarded (FIFO drain); no shadow write.
//  CHECK (1 clk): err_n = len_err | hdr_err | (len!=FRAME_LEN) | (chk!=sum).
//   - err_n=0: copy shadow to all cmd regs.
//   - err_n=1: cmd regs hold their previous value.
//   - err <= err_n. Go to DONE.
//  DONE: fd=1; err stable. When fs=0, go to IDLE (fd=0 next clk).
//  err holds its value until the next transaction start in IDLE.
//  Latency, fs high to fd high (len=N>0): N (READ) + 1 (LAST) + 1 (CHECK) + 1 = N+3 clks; FRAME_LEN frame = 15 clks.
//  len==0: no fifoc reads; fd rises 2 clks after fs.
//  fs held high in DONE: remain in DONE; no restart until fs seen low.
//  fs toggling during READ/LAST/CHECK is ignored.
//  data_len changing after latch is ignored.
//  Block always pops exactly len bytes, so fifoc stays frame-aligned even for short or long frames.
// TESTING
//  1. Frame 55 AA 01 02 03 04 05 06 07 08 09 2D, len=12
//     -> 12 rxen pulses; fd at fs+15; cmd_kdev=01..cmd_reg7=09; err=0.
//  2. Same frame with checksum 2C
//     -> err=1; all cmd regs keep their prior values; exactly 12 bytes popped.
//  3. Header 55 AB, otherwise valid
//     -> err=1, no commit. Then valid frame 55 AA 10x9 90
//     -> err=0; all regs 8'h10.
//  4. len=20 (valid 12 bytes + 8 junk)
//     -> 20 pops; err=1; no commit; fifoc empty.
//     len=5 -> 5 pops; err=1.
//  5. len=0 -> no rxen; fd 2 clks after fs; err=1.
//     fs held high in DONE for 10 clks -> fd stays 1, no re-run.
//  6. rst asserted at rd_cnt=6 of a valid frame
//     -> next clk: all outputs 0, state IDLE. Following valid frame parses correctly once fifoc is flushed.

Source files
------------

// File: rtl/fifoc2cs.sv
// Command-frame parser on the sys_clk side of fifoc: pops data_len bytes, validates the
// 55 AA header, the frame length and the checksum, then commits nine command registers atomically.
module fifoc2cs #(
    parameter logic [7:0]  HEAD0     = 8'h55,
    parameter logic [7:0]  HEAD1     = 8'hAA,
    parameter int unsigned FRAME_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [11:0] data_len,
    output logic        fifoc_rxen,
    input  logic [7:0]  fifoc_rxd,
    output logic [7:0]  cmd_kdev,
    output logic [7:0]  cmd_smpr,
    output logic [7:0]  cmd_filt,
    output logic [7:0]  cmd_mix0,
    output logic [7:0]  cmd_mix1,
    output logic [7:0]  cmd_reg4,
    output logic [7:0]  cmd_reg5,
    output logic [7:0]  cmd_reg6,
    output logic [7:0]  cmd_reg7,
    output logic        err
);

    localparam int unsigned NCMD = 9;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [11:0] r_len;
    logic [11:0] r_rd_cnt;
    logic        r_cap_vld;
    logic [11:0] r_cap_idx;
    logic [7:0]  r_sum;
    logic [7:0]  r_chk;
    logic        r_hdr_err;
    logic        r_len_err;
    logic        r_err;
    logic [7:0]  r_shadow [NCMD];
    logic [7:0]  r_cmd    [NCMD];

    logic        w_err_n;
    logic        w_in_body;

    // Body bytes (indices 2..FRAME_LEN-2) feed both the shadow registers and the checksum.
    assign w_in_body = (r_cap_idx >= 12'd2) && (r_cap_idx <= 12'(FRAME_LEN - 2));

    assign w_err_n = r_len_err | r_hdr_err
                   | (r_len != 12'(FRAME_LEN))
                   | (r_chk != r_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_rd_cnt  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_sum     <= '0;
            r_chk     <= '0;
            r_hdr_err <= 1'b0;
            r_len_err <= 1'b0;
            r_err     <= 1'b0;
            for (int unsigned i = 0; i < NCMD; i++) begin
                r_shadow[i] <= '0;
                r_cmd[i]    <= '0;
            end
        end else begin
            r_cap_vld <= (r_state == S_READ);

            if (r_cap_vld) begin
                r_cap_idx <= r_cap_idx + 12'd1;
                if (r_cap_idx == 12'd0 && fifoc_rxd != HEAD0)
                    r_hdr_err <= 1'b1;
                if (r_cap_idx == 12'd1 && fifoc_rxd != HEAD1)
                    r_hdr_err <= 1'b1;
                if (w_in_body)
                    r_sum <= r_sum + fifoc_rxd;
                for (int unsigned i = 0; i < NCMD; i++) begin
                    if (r_cap_idx == 12'(i + 2))
                        r_shadow[i] <= fifoc_rxd;
                end
                if (r_cap_idx == 12'(FRAME_LEN - 1))
                    r_chk <= fifoc_rxd;
            end

            case (r_state)
                S_IDLE: begin
                    if (fs) begin
                        r_len     <= data_len;
                        r_rd_cnt  <= '0;
                        r_cap_idx <= '0;
                        r_sum     <= '0;
                        r_chk     <= '0;
                        r_hdr_err <= 1'b0;
                        r_err     <= 1'b0;
                        if (data_len != 12'd0) begin
                            r_len_err <= 1'b0;
                            r_state   <= S_READ;
                        end else begin
                            r_len_err <= 1'b1;
                            r_state   <= S_CHECK;
                        end
                    end
                end
                S_READ: begin
                    r_rd_cnt <= r_rd_cnt + 12'd1;
                    if (r_rd_cnt == r_len - 12'd1)
                        r_state <= S_LAST;
                end
                S_LAST: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!w_err_n) begin
                        for (int unsigned i = 0; i < NCMD; i++)
                            r_cmd[i] <= r_shadow[i];
                    end
                    r_err   <= w_err_n;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!fs)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifoc_rxen = (r_state == S_READ);
    assign fd         = (r_state == S_DONE);
    assign err        = r_err;

    assign cmd_kdev = r_cmd[0];
    assign cmd_smpr = r_cmd[1];
    assign cmd_filt = r_cmd[2];
    assign cmd_mix0 = r_cmd[3];
    assign cmd_mix1 = r_cmd[4];
    assign cmd_reg4 = r_cmd[5];
    assign cmd_reg5 = r_cmd[6];
    assign cmd_reg6 = r_cmd[7];
    assign cmd_reg7 = r_cmd[8];

endmodule

// File: tb/tb_fifoc2cs.sv
// Scoreboard bench for fifoc2cs: a byte-queue fifoc model feeds frames; expected results are
// queued per transaction and checked by a monitor on each rising edge of fd.
module tb_fifoc2cs;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic [11:0] data_len;
    logic        fifoc_rxen;
    logic [7:0]  fifoc_rxd;
    logic [7:0]  cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
    logic [7:0]  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
    logic        err;

    fifoc2cs #(.HEAD0(8'h55), .HEAD1(8'hAA), .FRAME_LEN(12)) dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .data_len(data_len),
        .fifoc_rxen(fifoc_rxen), .fifoc_rxd(fifoc_rxd),
        .cmd_kdev(cmd_kdev), .cmd_smpr(cmd_smpr), .cmd_filt(cmd_filt),
        .cmd_mix0(cmd_mix0), .cmd_mix1(cmd_mix1), .cmd_reg4(cmd_reg4),
        .cmd_reg5(cmd_reg5), .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [71:0] regs;
        int          lat;
        int          npop;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] fq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pops = 0;
    int         start_cyc = 0;
    logic       fd_q = 1'b0;
    logic [71:0] w_regs;

    assign w_regs = {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
                     cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fifoc model: a read enable present at an edge yields the next byte 1 clk later.
    initial begin
        logic pend;
        fifoc_rxd = 8'h00;
        forever begin
            @(negedge clk);
            pend = fifoc_rxen;
            @(posedge clk);
            #1;
            if (pend) begin
                pops++;
                if (fq.size() > 0) fifoc_rxd = fq.pop_front();
                else               fifoc_rxd = 8'hEE;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fd && !fd_q) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fd: got fd=1 expected no completion at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("err",     72'(err), 72'(e.err));
                chk("regs",    w_regs, e.regs);
                chk("latency", 72'(cyc - start_cyc), 72'(e.lat));
                chk("pops",    72'(pops), 72'(e.npop));
            end
        end
        fd_q = fd;
    end

    task automatic push_n(input logic [159:0] v, input int n);
        for (int i = 0; i < n; i++)
            fq.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic run_txn(input logic [11:0] len, input logic e_err,
                           input logic [71:0] e_regs, input int hold, input bit toggle);
        exp_t e;
        int   n;
        e.err  = e_err;
        e.regs = e_regs;
        e.lat  = (len == 12'd0) ? 2 : int'(len) + 3;
        e.npop = int'(len);
        @(posedge clk); #1;
        pops      = 0;
        data_len  = len;
        sbq.push_back(e);
        start_cyc = cyc;
        fs        = 1'b1;
        @(posedge clk); #1;
        data_len  = 12'hABC;
        if (toggle) begin
            repeat (3) @(posedge clk);
            #1 fs = 1'b0;
            @(posedge clk);
            #1 fs = 1'b1;
        end
        n = 0;
        while (!fd && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!fd) begin
            checks++;
            errors++;
            $display("FAIL fd_timeout: got fd=0 expected fd=1 within 200 clks");
            if (sbq.size() > 0) e = sbq.pop_back();
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("fd_hold",   72'(fd), 72'(1));
            chk("hold_pops", 72'(pops), 72'(len));
        end
        @(posedge clk); #1;
        fs = 1'b0;
        repeat (2) @(negedge clk);
        chk("fd_low",     72'(fd), 72'(0));
        chk("fifo_empty", 72'(fq.size()), 72'(0));
    endtask

    localparam logic [71:0] R_SEQ = 72'h01_02_03_04_05_06_07_08_09;
    localparam logic [71:0] R_10  = 72'h10_10_10_10_10_10_10_10_10;

    initial begin
        rst      = 1'b1;
        fs       = 1'b0;
        data_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_fd",   72'(fd), 72'(0));
        chk("rst_rxen", 72'(fifoc_rxen), 72'(0));
        chk("rst_err",  72'(err), 72'(0));
        chk("rst_regs", w_regs, 72'(0));

        // 1: valid frame, checksum 0x2D = 1+2+..+9
        push_n(160'h55AA_010203040506070809_2D, 12);
        run_txn(12'd12, 1'b0, R_SEQ, 0, 1'b0);
        // 2: bad checksum, registers keep previous values
        push_n(160'h55AA_010203040506070809_2C, 12);
        run_txn(12'd12, 1'b1, R_SEQ, 0, 1'b0);
        // 3: bad header, then valid all-0x10 frame (sum 0x90), fs glitch mid-READ
        push_n(160'h55AB_010203040506070809_2D, 12);
        run_txn(12'd12, 1'b1, R_SEQ, 0, 1'b0);
        push_n(160'h55AA_101010101010101010_90, 12);
        run_txn(12'd12, 1'b0, R_10, 0, 1'b1);
        // 4: long frame (valid 12 + 8 junk), short frame
        push_n(160'h55AA_010203040506070809_2D, 12);
        push_n(160'hDEADBEEF_CAFEF00D, 8);
        run_txn(12'd20, 1'b1, R_10, 0, 1'b0);
        push_n(160'h55AA_010203, 5);
        run_txn(12'd5, 1'b1, R_10, 0, 1'b0);
        // 5: zero length, fs held in DONE
        run_txn(12'd0, 1'b1, R_10, 10, 1'b0);

        // 6: reset while rd_cnt==6 of a valid frame
        push_n(160'h55AA_010203040506070809_2D, 12);
        @(posedge clk); #1;
        pops     = 0;
        data_len = 12'd12;
        fs       = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_rxen_before", 72'(fifoc_rxen), 72'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_fd",   72'(fd), 72'(0));
        chk("abort_rxen", 72'(fifoc_rxen), 72'(0));
        chk("abort_err",  72'(err), 72'(0));
        chk("abort_regs", w_regs, 72'(0));
        rst = 1'b0;
        fs  = 1'b0;
        repeat (3) @(posedge clk);
        #1 fq.delete();
        push_n(160'h55AA_010203040506070809_2D, 12);
        run_txn(12'd12, 1'b0, R_SEQ, 0, 1'b0);

        repeat (5) @(posedge clk);
        chk("sb_drained", 72'(sbq.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
